rf_2p_param: RTL and testbench
==============================

# rf_2p_param

Parametrised single-clock two-port register file: one read port (A), one write port (B). It succeeds the fixed 64x16 dual-clock macro and adds the following:
- configurable width, depth and read latency;
- an active-low per-bit write mask;
- a defined read/write collision policy;
- a hardware clear sequencer that zeroes every entry after reset.

It serves as local storage for datapath blocks that need deterministic simulation behaviour and a known-zero power-up state.

## Interface
- DW, 16, data width in bits (1..64)
- AW, 6, address width
- DEPTH, 64, number of entries (2 .. 2**AW)
- RD_LAT, 1, read latency in cycles, legal values 1 or 2
- BYPASS, 1, collision policy: 1 = write-first (forward DB), 0 = read-first (old data)

Ports:
- CLK  in  1  single clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- CENA  in  1  read enable, active-low
- AA  in  AW  read address
- QA  out  DW  read data, registered
- QVALIDA  out  1  one-cycle pulse, QA updated this cycle
- CENB  in  1  write enable, active-low
- AB  in  AW  write address
- DB  in  DW  write data
- WENB  in  DW  per-bit write mask, 0 = write bit, 1 = keep bit
- INIT_BUSY  out  1  clear sequence in progress, all accesses ignored

## Operation
Reset values (RST_N low): QA=0, QVALIDA=0, INIT_BUSY=1, FSM=CLEAR, clear pointer=0, pipeline stage valid=0. Memory contents are not reset directly; the sequencer clears them.

FSM states and transitions:
- CLEAR: each cycle, writes 0 to mem[ptr] and increments ptr. When ptr==DEPTH-1 is written, moves to READY. Takes exactly DEPTH cycles.
- READY: normal operation. Returns to CLEAR only via reset.

Behaviour during CLEAR:
- CENA and CENB are treated as 1.
- No QVALIDA pulses.
- QA holds 0.

Behaviour when RST_N asserts mid-CLEAR or mid-read:
- Everything returns to reset values asynchronously.
- Any in-flight read is discarded.
- The clear restarts from 0 after release.

Write (READY, CENB=0, AB<DEPTH):
- mem[AB] <= (DB & ~WENB) | (mem[AB] & WENB).
- WENB all-ones is a legal no-op.
- AB>=DEPTH: ignored, no state change.

Read (READY, CENA=0):
- The address is sampled on the edge. Data appears on QA after RD_LAT edges, with QVALIDA high in that same cycle.
- AA>=DEPTH returns all zeros, with QVALIDA still pulsed.
- QA holds its last value when no read completes.

Collision (CENA=0, CENB=0, AA==AB, same edge):
- BYPASS=1: the read returns the merged new word (DB & ~WENB) | (old & WENB).
- BYPASS=0: the read returns the old word.
- The write always completes.

Write then read to the same address on the next cycle always returns the new data, whatever BYPASS is set to.

Back-to-back reads: one read is accepted per cycle at full throughput for both RD_LAT values. QVALIDA stays high continuously under continuous CENA=0.

## Timing
- Read latency equals RD_LAT edges from the sampling edge.
  - RD_LAT=1: array read and QA register in the same stage.
  - RD_LAT=2: array read registered, then a QA output register.
- Write latency: contents are updated on the sampling edge and visible to a read sampled on the next edge.
- INIT_BUSY deasserts on the edge where the FSM enters READY, DEPTH edges after the first edge following RST_N release. The first access is accepted on the edge after INIT_BUSY is seen low.
- No combinational path from any input to any output.
- RST_N is asserted asynchronously; the integration layer synchronises its deassertion.

## Test plan
- Reset release with DEPTH=64: INIT_BUSY stays high for exactly 64 cycles. A read of every address afterwards returns 0x0000, and QVALIDA pulses for each read.
- Write 0xA5A5 to addr 3 with WENB=0x0000, then write 0xFFFF to addr 3 with WENB=0xFF00 -> a read of addr 3 returns 0xA5FF.
- Same-edge write 0x1234 and read of addr 10, which holds 0x0BAD: BYPASS=1 -> QA=0x1234; BYPASS=0 -> QA=0x0BAD. The next read of addr 10 returns 0x1234 in both cases.
- RD_LAT=2 with 8 consecutive reads of addrs 0..7 (preloaded with the index value):
  - QA shows 0..7 on cycles 2..9;
  - QVALIDA is high for 8 cycles;
  - no bubbles.
- Assert RST_N low at clear cycle 30, release, then write/read during INIT_BUSY: the clear restarts and lasts 64 cycles, the writes are ignored, and all entries read back 0.
- DEPTH=40, AW=6: a write to addr 45 is ignored. A read of addr 45 returns 0 with QVALIDA=1, and addr 5 (45 mod 40) is not corrupted.

Source files
------------

// File: rtl/rf_2p_param.sv
// Parametrised single-clock register file: one read port (A), one masked write port (B),
// with a post-reset clear sequencer and a selectable read/write collision policy.
module rf_2p_param #(
    parameter int DW     = 16,
    parameter int AW     = 6,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CENA,
    input  logic [AW-1:0] AA,
    output logic [DW-1:0] QA,
    output logic          QVALIDA,
    input  logic          CENB,
    input  logic [AW-1:0] AB,
    input  logic [DW-1:0] DB,
    input  logic [DW-1:0] WENB,
    output logic          INIT_BUSY
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic [DW-1:0] mem [DEPTH];

    logic          rd_en, wr_en, rd_in_range;
    logic [DW-1:0] rd_old, wr_word, rd_word;

    assign rd_en       = (state == READY) && !CENA;
    assign wr_en       = (state == READY) && !CENB && ({1'b0, AB} < DEPTH_W);
    assign rd_in_range = {1'b0, AA} < DEPTH_W;
    assign rd_old      = rd_in_range ? mem[AA] : '0;
    assign wr_word     = (DB & ~WENB) | (mem[AB] & WENB);
    // Write-first forwarding only applies when the write actually lands on the read address.
    assign rd_word     = ((BYPASS != 0) && wr_en && (AA == AB)) ? wr_word : rd_old;
    assign INIT_BUSY   = (state == CLEAR);

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && ptr == LAST_PTR)
            state_nxt = READY;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR)
                ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == CLEAR)
            mem[ptr] <= '0;
        else if (wr_en)
            mem[AB] <= wr_word;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DW-1:0] s1_data;
            logic          s1_valid;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    s1_data  <= '0;
                    s1_valid <= 1'b0;
                    QA       <= '0;
                    QVALIDA  <= 1'b0;
                end else begin
                    s1_valid <= rd_en;
                    if (rd_en)
                        s1_data <= rd_word;
                    QVALIDA <= s1_valid;
                    if (s1_valid)
                        QA <= s1_data;
                end
            end
        end else begin : g_lat1
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    QA      <= '0;
                    QVALIDA <= 1'b0;
                end else begin
                    QVALIDA <= rd_en;
                    if (rd_en)
                        QA <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rf_2p_param.sv
// Directed bench for rf_2p_param: three instances (default, read-first/RD_LAT=2, DEPTH=40)
// share one stimulus stream and are checked against hand-computed vectors.
module tb_rf_2p_param;

    logic        clk, rst_n, cena, cenb;
    logic [5:0]  aa, ab;
    logic [15:0] db, wenb;
    logic [15:0] qa0, qa1, qa2;
    logic        qv0, qv1, qv2, busy0, busy1, busy2;

    int n_tests = 0;
    int n_fail  = 0;

    rf_2p_param #(.DW(16), .AW(6), .DEPTH(64), .RD_LAT(1), .BYPASS(1)) u0 (
        .CLK(clk), .RST_N(rst_n), .CENA(cena), .AA(aa), .QA(qa0), .QVALIDA(qv0),
        .CENB(cenb), .AB(ab), .DB(db), .WENB(wenb), .INIT_BUSY(busy0));
    rf_2p_param #(.DW(16), .AW(6), .DEPTH(64), .RD_LAT(2), .BYPASS(0)) u1 (
        .CLK(clk), .RST_N(rst_n), .CENA(cena), .AA(aa), .QA(qa1), .QVALIDA(qv1),
        .CENB(cenb), .AB(ab), .DB(db), .WENB(wenb), .INIT_BUSY(busy1));
    rf_2p_param #(.DW(16), .AW(6), .DEPTH(40), .RD_LAT(1), .BYPASS(1)) u2 (
        .CLK(clk), .RST_N(rst_n), .CENA(cena), .AA(aa), .QA(qa2), .QVALIDA(qv2),
        .CENB(cenb), .AB(ab), .DB(db), .WENB(wenb), .INIT_BUSY(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [5:0]  aa;
        logic        wr;
        logic [5:0]  ab;
        logic [15:0] db;
        logic [15:0] wenb;
        logic        ev0;
        logic [15:0] eq0;
        logic        ev1;
        logic [15:0] eq1;
        logic        ev2;
        logic [15:0] eq2;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic rd, input logic [5:0] a_rd, input logic wr,
                                input logic [5:0] a_wr, input logic [15:0] d, input logic [15:0] m,
                                input logic v0, input logic [15:0] q0, input logic v1,
                                input logic [15:0] q1, input logic v2, input logic [15:0] q2);
        vec_t v;
        v.rd = rd; v.aa = a_rd; v.wr = wr; v.ab = a_wr; v.db = d; v.wenb = m;
        v.ev0 = v0; v.eq0 = q0; v.ev1 = v1; v.eq1 = q1; v.ev2 = v2; v.eq2 = q2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cena = 1'b1; cenb = 1'b1; aa = '0; ab = '0; db = '0; wenb = '1;
    endtask

    initial begin
        int first0, first1, first2, bad;

        // rd, aa, wr, ab, db, wenb | u0 qv,qa | u1 qv,qa | u2 qv,qa
        vecs[0]  = mk(1'b0, 6'd0,  1'b1, 6'd3,  16'hA5A5, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        vecs[1]  = mk(1'b0, 6'd0,  1'b1, 6'd3,  16'hFFFF, 16'hFF00, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        vecs[2]  = mk(1'b1, 6'd3,  1'b0, 6'd0,  16'h0000, 16'hFFFF, 1'b1, 16'hA5FF, 1'b0, 16'h0000, 1'b1, 16'hA5FF);
        vecs[3]  = mk(1'b0, 6'd0,  1'b1, 6'd10, 16'h0BAD, 16'h0000, 1'b0, 16'hA5FF, 1'b1, 16'hA5FF, 1'b0, 16'hA5FF);
        vecs[4]  = mk(1'b1, 6'd10, 1'b1, 6'd10, 16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'hA5FF, 1'b1, 16'h1234);
        vecs[5]  = mk(1'b1, 6'd10, 1'b0, 6'd0,  16'h0000, 16'hFFFF, 1'b1, 16'h1234, 1'b1, 16'h0BAD, 1'b1, 16'h1234);
        vecs[6]  = mk(1'b0, 6'd0,  1'b1, 6'd5,  16'h5555, 16'h0000, 1'b0, 16'h1234, 1'b1, 16'h1234, 1'b0, 16'h1234);
        vecs[7]  = mk(1'b0, 6'd0,  1'b1, 6'd45, 16'hDEAD, 16'h0000, 1'b0, 16'h1234, 1'b0, 16'h1234, 1'b0, 16'h1234);
        vecs[8]  = mk(1'b1, 6'd45, 1'b0, 6'd0,  16'h0000, 16'hFFFF, 1'b1, 16'hDEAD, 1'b0, 16'h1234, 1'b1, 16'h0000);
        vecs[9]  = mk(1'b1, 6'd5,  1'b0, 6'd0,  16'h0000, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 16'hDEAD, 1'b1, 16'h5555);
        vecs[10] = mk(1'b0, 6'd0,  1'b0, 6'd0,  16'h0000, 16'hFFFF, 1'b0, 16'h5555, 1'b1, 16'h5555, 1'b0, 16'h5555);
        vecs[11] = mk(1'b1, 6'd3,  1'b1, 6'd3,  16'h0000, 16'h00FF, 1'b1, 16'h00FF, 1'b0, 16'h5555, 1'b1, 16'h00FF);
        vecs[12] = mk(1'b1, 6'd3,  1'b0, 6'd0,  16'h0000, 16'hFFFF, 1'b1, 16'h00FF, 1'b1, 16'hA5FF, 1'b1, 16'h00FF);
        vecs[13] = mk(1'b1, 6'd7,  1'b1, 6'd7,  16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 16'h00FF, 1'b1, 16'h0000);
        vecs[14] = mk(1'b1, 6'd7,  1'b0, 6'd0,  16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000);
        vecs[15] = mk(1'b0, 6'd0,  1'b0, 6'd0,  16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000);
        vecs[16] = mk(1'b0, 6'd0,  1'b0, 6'd0,  16'h0000, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);

        rst_n = 1'b0;
        idle();
        tick();
        tick();
        chk("reset qa0", 32'(qa0), 32'h0);
        chk("reset qv0", 32'(qv0), 32'h0);
        chk("reset busy0", 32'(busy0), 32'h1);
        chk("reset qa1", 32'(qa1), 32'h0);
        chk("reset qv1", 32'(qv1), 32'h0);
        chk("reset busy2", 32'(busy2), 32'h1);

        // First clear, interrupted at cycle 30 while accesses are attempted
        rst_n = 1'b1;
        bad = 0;
        for (int k = 1; k <= 30; k++) begin
            cena = 1'b0; aa = 6'(k); cenb = 1'b0; ab = 6'(k); db = 16'hFFFF; wenb = '0;
            tick();
            if (!busy0 || !busy1 || !busy2 || qv0 || qv1 || qv2 || qa0 != 0 || qa1 != 0 || qa2 != 0)
                bad++;
        end
        chk("clear1 quiet", 32'(bad), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midclear reset busy0", 32'(busy0), 32'h1);
        chk("midclear reset busy2", 32'(busy2), 32'h1);
        tick();
        rst_n = 1'b1;

        // Restarted clear: measure busy length, keep attempting accesses early on
        first0 = 0; first1 = 0; first2 = 0; bad = 0;
        for (int k = 1; k <= 70; k++) begin
            if (k <= 39) begin
                cena = 1'b0; aa = 6'(k); cenb = 1'b0; ab = 6'(k); db = 16'hFFFF; wenb = '0;
            end else begin
                idle();
            end
            tick();
            if (!busy0 && first0 == 0) first0 = k;
            if (!busy1 && first1 == 0) first1 = k;
            if (!busy2 && first2 == 0) first2 = k;
            if (qv0 || qv1 || qv2) bad++;
        end
        chk("busy cycles u0", 32'(first0), 32'd64);
        chk("busy cycles u1", 32'(first1), 32'd64);
        chk("busy cycles u2", 32'(first2), 32'd40);
        chk("no qvalid while clearing", 32'(bad), 32'h0);

        // Full read sweep: every entry zero, QVALIDA continuous
        for (int i = 0; i < 64; i++) begin
            cena = 1'b0; aa = 6'(i);
            tick();
            chk($sformatf("sweep u0 qv %0d", i), 32'(qv0), 32'h1);
            chk($sformatf("sweep u0 qa %0d", i), 32'(qa0), 32'h0);
            chk($sformatf("sweep u2 qv %0d", i), 32'(qv2), 32'h1);
            chk($sformatf("sweep u2 qa %0d", i), 32'(qa2), 32'h0);
            chk($sformatf("sweep u1 qv %0d", i), 32'(qv1), (i == 0) ? 32'h0 : 32'h1);
            chk($sformatf("sweep u1 qa %0d", i), 32'(qa1), 32'h0);
        end
        idle();
        tick();
        chk("sweep tail u1 qv", 32'(qv1), 32'h1);
        chk("sweep tail u0 qv", 32'(qv0), 32'h0);
        tick();
        tick();

        for (int i = 0; i < 17; i++) begin
            cena = ~vecs[i].rd; aa = vecs[i].aa;
            cenb = ~vecs[i].wr; ab = vecs[i].ab; db = vecs[i].db; wenb = vecs[i].wenb;
            tick();
            chk($sformatf("vec%0d u0 qv", i), 32'(qv0), 32'(vecs[i].ev0));
            chk($sformatf("vec%0d u0 qa", i), 32'(qa0), 32'(vecs[i].eq0));
            chk($sformatf("vec%0d u1 qv", i), 32'(qv1), 32'(vecs[i].ev1));
            chk($sformatf("vec%0d u1 qa", i), 32'(qa1), 32'(vecs[i].eq1));
            chk($sformatf("vec%0d u2 qv", i), 32'(qv2), 32'(vecs[i].ev2));
            chk($sformatf("vec%0d u2 qa", i), 32'(qa2), 32'(vecs[i].eq2));
        end

        // Preload 0..7 with their index, then eight back-to-back reads
        for (int i = 0; i < 8; i++) begin
            cena = 1'b1; cenb = 1'b0; ab = 6'(i); db = 16'(i); wenb = '0;
            tick();
        end
        for (int t = 1; t <= 11; t++) begin
            if (t <= 8) begin
                cena = 1'b0; aa = 6'(t - 1);
            end else begin
                cena = 1'b1;
            end
            cenb = 1'b1;
            tick();
            chk($sformatf("b2b t%0d u1 qv", t), 32'(qv1), (t >= 2 && t <= 9) ? 32'h1 : 32'h0);
            chk($sformatf("b2b t%0d u1 qa", t), 32'(qa1), (t < 2) ? 32'h0 : ((t <= 9) ? 32'(t - 2) : 32'd7));
            chk($sformatf("b2b t%0d u0 qv", t), 32'(qv0), (t <= 8) ? 32'h1 : 32'h0);
            chk($sformatf("b2b t%0d u0 qa", t), 32'(qa0), (t <= 8) ? 32'(t - 1) : 32'd7);
        end

        // Reset asserted with reads in flight
        cena = 1'b0; aa = 6'd3;
        tick();
        chk("preflight u0 qa", 32'(qa0), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("midread reset u0 qa", 32'(qa0), 32'h0);
        chk("midread reset u0 qv", 32'(qv0), 32'h0);
        chk("midread reset u1 qa", 32'(qa1), 32'h0);
        chk("midread reset u0 busy", 32'(busy0), 32'h1);
        idle();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (qv0 || qv1 || qv2) bad++;
        end
        chk("in-flight read discarded", 32'(bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
